// File: rtl/uut_result_capture_if.sv
// rtl/uut_result_capture_if.sv - record byte stream handshake between capture stage and its consumer
interface uut_result_capture_if;
    logic [7:0] byte_o;
    logic       byte_valid;
    logic       byte_ack;

    modport master (
        output byte_o,
        output byte_valid,
        input  byte_ack
    );

    modport slave (
        input  byte_o,
        input  byte_valid,
        output byte_ack
    );
endinterface

// File: rtl/uut_result_capture.sv
// rtl/uut_result_capture.sv - measures UUT latencies, latches the result and streams a 17-byte record
module uut_result_capture #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rst_uut,
    input  logic                          encdec_uut,
    input  logic [63:0]                   block_o_uut,
    input  logic                          end_key_signal_uut,
    input  logic                          end_enc_uut,
    input  logic                          end_dec_uut,
    uut_result_capture_if.master          rec,
    output logic                          done,
    output logic                          timeout,
    output logic [2:0]                    state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        RUN  = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    // cnt holds the number of completed RUN cycles; cnt_now is the count the current cycle is seen as,
    // so the first RUN cycle reports 1 while the register itself is cleared at run start.
    logic [31:0] cnt;
    logic [31:0] cnt_now;
    logic [31:0] key_cycles;
    logic [31:0] op_cycles;
    logic [63:0] result;
    logic        key_seen;
    logic        mode;
    logic [4:0]  idx;
    logic        end_key;
    logic        end_op;

    assign cnt_now = cnt + 32'd1;
    assign end_key = end_key_signal_uut;
    assign end_op  = mode ? end_enc_uut : end_dec_uut;

    // Record byte i (0 = status, MSB first) out of the captured fields.
    function automatic logic [7:0] rec_byte(
        input logic [4:0]  i,
        input logic [7:0]  st,
        input logic [63:0] r,
        input logic [31:0] k,
        input logic [31:0] o
    );
        logic [135:0] v;
        v = {st, r, k, o};
        v = v << {i, 3'b000};
        return v[135:128];
    endfunction

    // Control FSM plus all capture, counting and record-serialising registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            state_dbg      <= 3'd0;
            cnt            <= 32'd0;
            key_cycles     <= 32'd0;
            op_cycles      <= 32'd0;
            result         <= 64'd0;
            key_seen       <= 1'b0;
            mode           <= 1'b0;
            idx            <= 5'd0;
            rec.byte_o     <= 8'd0;
            rec.byte_valid <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rst_uut) begin
                        state     <= ARM;
                        state_dbg <= ARM;
                    end
                end
                ARM: begin
                    if (!rst_uut) begin
                        state      <= RUN;
                        state_dbg  <= RUN;
                        cnt        <= 32'd0;
                        key_cycles <= 32'd0;
                        key_seen   <= 1'b0;
                        op_cycles  <= 32'd0;
                        mode       <= encdec_uut;
                        timeout    <= 1'b0;
                        done       <= 1'b0;
                    end
                end
                RUN: begin
                    if (rst_uut) begin
                        // Aborted run: counters are simply re-cleared on the next start.
                        state     <= ARM;
                        state_dbg <= ARM;
                    end else begin
                        cnt <= cnt_now;
                        if (end_key && !key_seen) begin
                            key_cycles <= cnt_now;
                            key_seen   <= 1'b1;
                        end
                        if (end_op) begin
                            result         <= block_o_uut;
                            op_cycles      <= cnt_now;
                            idx            <= 5'd0;
                            rec.byte_valid <= 1'b1;
                            rec.byte_o     <= {5'b0, key_seen | end_key, mode, 1'b0};
                            state          <= SEND;
                            state_dbg      <= SEND;
                        end else if (cnt_now == TIMEOUT_CYCLES) begin
                            timeout        <= 1'b1;
                            result         <= block_o_uut;
                            op_cycles      <= 32'hFFFF_FFFF;
                            idx            <= 5'd0;
                            rec.byte_valid <= 1'b1;
                            rec.byte_o     <= {5'b0, key_seen | end_key, mode, 1'b1};
                            state          <= SEND;
                            state_dbg      <= SEND;
                        end
                    end
                end
                SEND: begin
                    // rst_uut is deliberately ignored here so a record is never truncated.
                    if (rec.byte_valid && rec.byte_ack) begin
                        if (idx == 5'd16) begin
                            rec.byte_valid <= 1'b0;
                            rec.byte_o     <= 8'd0;
                            done           <= 1'b1;
                            state          <= DONE;
                            state_dbg      <= DONE;
                        end else begin
                            idx        <= idx + 5'd1;
                            rec.byte_o <= rec_byte(idx + 5'd1,
                                                   {5'b0, key_seen, mode, timeout},
                                                   result, key_cycles, op_cycles);
                        end
                    end
                end
                DONE: begin
                    if (rst_uut) begin
                        done      <= 1'b0;
                        state     <= ARM;
                        state_dbg <= ARM;
                    end
                end
                default: begin
                    state     <= IDLE;
                    state_dbg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uut_result_capture.md
# uut_result_capture

Result-capture and framing stage between the PRESENT UUT and `fsm_autotest`. It watches the UUT control and result signals and measures the key-schedule and encrypt/decrypt latencies in clock cycles. It latches the 64-bit output block and detects hung runs by timeout. It then serialises a fixed 17-byte record through a valid/ack byte handshake that the FSM forwards to the SD card writer.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 32'd100000: run cycle count at which a missing end signal is declared a timeout. Legal range 1 to 2^32-2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rst_uut`  in  1  UUT reset as driven by the FSM; active-high.
- `encdec_uut`  in  1  operation select: 1 = encrypt, 0 = decrypt. Sampled at run start.
- `block_o_uut`  in  64  UUT output block.
- `end_key_signal_uut`  in  1  key schedule finished.
- `end_enc_uut`  in  1  encryption finished.
- `end_dec_uut`  in  1  decryption finished.
- `byte_o`  out  8  current record byte.
- `byte_valid`  out  1  `byte_o` holds a valid byte.
- `byte_ack`  in  1  consumer accepted `byte_o`.
- `done`  out  1  record fully transferred; level output.
- `timeout`  out  1  last run timed out; level output.
- `state_dbg`  out  3  current state encoding, for the debug mux.

## Operation
- States:
  - IDLE=0
  - ARM=1
  - RUN=2
  - SEND=3
  - DONE=4
- IDLE: moves to ARM when `rst_uut`=1.
- ARM: moves to RUN on the first cycle with `rst_uut`=0. On that edge:
  - clear `cnt`, `key_cycles` and `key_seen`;
  - set `op_cycles` = 0;
  - latch `encdec_uut` into `mode`;
  - clear `timeout` and `done`.
- RUN, counting:
  - 32-bit `cnt` increments every cycle, so the first RUN cycle sees `cnt`=1.
  - `end_key` = `end_key_signal_uut`.
  - `end_op` = `mode` ? `end_enc_uut` : `end_dec_uut`.
- RUN, key schedule:
  - On the first cycle with `end_key`=1 and `key_seen`=0, set `key_cycles` = `cnt` (current value, pre-increment) and `key_seen` = 1.
  - Later pulses are ignored.
- RUN, operation end:
  - On the first cycle with `end_op`=1, set `result` = `block_o_uut` and `op_cycles` = `cnt`, then move to SEND.
  - If `end_key` and `end_op` occur in the same cycle, both are latched.
- RUN, timeout:
  - When `cnt` = `TIMEOUT_CYCLES` and `end_op`=0, set `timeout` = 1, `result` = `block_o_uut` and `op_cycles` = 32'hFFFF_FFFF, then move to SEND.
  - `end_op` in that same cycle wins; no timeout is flagged.
- RUN, abort: if `rst_uut`=1 during RUN, move to ARM. No record is emitted and the counters are discarded.
- Record layout, index 0..16, transmitted MSB first:
  - byte 0 = status {5'b0, `key_seen`, `mode`, `timeout`};
  - bytes 1-8 = `result`[63:0];
  - bytes 9-12 = `key_cycles`;
  - bytes 13-16 = `op_cycles`.
- SEND:
  - 5-bit index `idx` starts at 0.
  - Each accepted byte (`byte_valid` & `byte_ack`) increments `idx`.
  - After byte 16 is accepted, move to DONE.
  - `rst_uut` is ignored in SEND; a record is never truncated.
- DONE: `done`=1. Moves to ARM when `rst_uut`=1, which clears `done`. `timeout` holds its value until the next ARM→RUN edge.

## Timing
- Reset (`rst`=0, asynchronous):
  - state = IDLE;
  - `byte_o` = 0, `byte_valid` = 0, `done` = 0, `timeout` = 0, `state_dbg` = 0;
  - all internal registers = 0.
- All outputs are registered.
- Latency from end signal to first byte:
  - end-signal edge N latches the data;
  - `byte_valid`=1 with byte 0 from edge N+1.
- Handshake:
  - `byte_valid` stays high across the whole record.
  - `byte_o` is stable while `byte_ack`=0.
  - On an edge with `byte_valid` & `byte_ack`, `byte_o` shows the next byte after that edge.
  - On the edge accepting byte 16, `byte_valid` falls and `done` rises.
  - `byte_ack` with `byte_valid`=0 is ignored.
- Best case: ack held high gives 17 cycles per record.
- `cnt` never wraps, because the timeout fires first.
- `rst` mid-SEND returns the block to IDLE and drops `byte_valid` immediately.

## Test plan
- Encrypt run: `rst_uut` 1→0, `encdec_uut`=1, `end_key` at `cnt`=33, `end_enc_uut` at `cnt`=65 with block 64'h5579C1387B228445, ack held high. Required stream: 06, 55 79 C1 38 7B 22 84 45, 00 00 00 21, 00 00 00 41, then `done`=1.
- Decrypt run, `encdec_uut`=0: `end_enc_uut` pulses at cnt 10, `end_dec_uut` at cnt 70. Required: `end_enc_uut` ignored, `op_cycles`=00000046, status bit1=0.
- Timeout, with `TIMEOUT_CYCLES`=50 and no end signal. Required:
  - `timeout`=1 on the edge where `cnt`=50;
  - status 0x01 if no key end was seen;
  - `op_cycles` bytes FF FF FF FF.
- Abort: `rst_uut` reasserted at cnt 20. Required: `byte_valid` never rises and state returns to ARM. A following clean run produces a correct record.
- Back-pressure: ack toggled randomly, 1 cycle in 4. Required: exactly 17 distinct bytes in order, with no byte skipped or duplicated.
- Async reset asserted during SEND at byte 5. Required: all outputs 0 immediately; state IDLE.
